// File: rtl/frame_seq_pkg.sv
// Shared types and default constants for the frame sequencer.
// FRAME_SEQ_HBLANK_EN adds the ST_HBLANK state used for inter-row blanking.
package frame_seq_pkg;

  localparam int ADDR_W_DEF   = 20;
  localparam int DIM_W_DEF    = 11;
  localparam int BPP_DEF      = 3;
  localparam int PIPE_LAT_DEF = 4;
  localparam int HBLANK_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DONE   = 3'd3
`ifdef FRAME_SEQ_HBLANK_EN
    ,
    ST_HBLANK = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/frame_seq_if.sv
// Command/status and pixel-stream bundle between frame sequencer and its host/pipeline.
interface frame_seq_if #(
  parameter int ADDR_W = 20,
  parameter int DIM_W  = 11
) ();
  logic              start;
  logic [DIM_W-1:0]  width;
  logic [DIM_W-1:0]  height;
  logic [1:0]        row_pad;
  logic              stall;
  logic              busy;
  logic              done;
  logic              en;
  logic              hsync;
  logic              vsync;
  logic [DIM_W-1:0]  x;
  logic [DIM_W-1:0]  y;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  modport master (
    output start, width, height, row_pad, stall,
    input  busy, done, en, hsync, vsync, x, y, rd_addr, wr_en, wr_addr
  );

  modport slave (
    input  start, width, height, row_pad, stall,
    output busy, done, en, hsync, vsync, x, y, rd_addr, wr_en, wr_addr
  );
endinterface

// File: rtl/seq_delay_line.sv
// Fixed-latency valid+address shift register carrying read addresses to write-back.
module seq_delay_line #(
  parameter int ADDR_W = 20,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  logic [DEPTH-1:0]  valid_r;
  logic [ADDR_W-1:0] addr_r [DEPTH];

  // Shift every cycle regardless of stall; reset flushes all in-flight entries
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) addr_r[i] <= '0;
    end else begin
      valid_r[0] <= in_valid;
      addr_r[0]  <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        addr_r[i]  <= addr_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_addr  = addr_r[DEPTH-1];

endmodule

// File: rtl/frame_sequencer.sv
// Raster-scan controller: emits pixel read addresses with syncs and delayed write-back addresses.
// Define FRAME_SEQ_HBLANK_EN to insert HBLANK idle cycles after every row except the last.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DIM_W    = DIM_W_DEF,
  parameter int BPP      = BPP_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int HBLANK   = HBLANK_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  frame_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(PIPE_LAT + 2);
`ifdef FRAME_SEQ_HBLANK_EN
  localparam state_t ROW_GAP = ST_HBLANK;
  localparam int     BLK_W   = $clog2(HBLANK + 1);
`else
  localparam state_t ROW_GAP = ST_SCAN;
`endif

  state_t            state_r, state_next_s;
  logic [DIM_W-1:0]  w_r, h_r, x_cnt_r, y_cnt_r;
  logic [1:0]        pad_r;
  logic [ADDR_W-1:0] addr_cnt_r;
  logic [CNT_W-1:0]  inflight_r, inflight_next_s;
  logic              en_r, hsync_r, vsync_r, busy_r, done_r;
  logic [DIM_W-1:0]  x_r, y_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              wb_valid_s;
  logic [ADDR_W-1:0] wb_addr_s;
`ifdef FRAME_SEQ_HBLANK_EN
  logic [BLK_W-1:0]  blank_cnt_r;
`endif

  logic              accept_s, zero_s, step_s, row_end_s, last_s;
  logic [DIM_W-1:0]  eff_w_s, eff_h_s, cur_x_s, cur_y_s, x_nxt_s, y_nxt_s;
  logic [1:0]        eff_pad_s;
  logic [ADDR_W-1:0] cur_addr_s, addr_nxt_s;
  state_t            scan_next_s;

  // Scan datapath: the accepting cycle already presents pixel (0,0) from the live inputs
  always_comb begin
    accept_s   = (state_r == ST_IDLE) && bus.start;
    zero_s     = (bus.width == '0) || (bus.height == '0);
    eff_w_s    = accept_s ? bus.width   : w_r;
    eff_h_s    = accept_s ? bus.height  : h_r;
    eff_pad_s  = accept_s ? bus.row_pad : pad_r;
    cur_x_s    = accept_s ? '0 : x_cnt_r;
    cur_y_s    = accept_s ? '0 : y_cnt_r;
    cur_addr_s = accept_s ? '0 : addr_cnt_r;
    step_s     = ((state_r == ST_SCAN) || (accept_s && !zero_s)) && !bus.stall;
    row_end_s  = (cur_x_s == eff_w_s - DIM_W'(1));
    last_s     = row_end_s && (cur_y_s == eff_h_s - DIM_W'(1));
    x_nxt_s    = cur_x_s;
    y_nxt_s    = cur_y_s;
    addr_nxt_s = cur_addr_s;
    if (step_s) begin
      x_nxt_s    = row_end_s ? '0 : cur_x_s + DIM_W'(1);
      y_nxt_s    = row_end_s ? cur_y_s + DIM_W'(1) : cur_y_s;
      addr_nxt_s = cur_addr_s + ADDR_W'(BPP) + (row_end_s ? ADDR_W'(eff_pad_s) : ADDR_W'(0));
    end else begin
      x_nxt_s    = cur_x_s;
    end
    inflight_next_s = inflight_r + (step_s ? CNT_W'(1) : CNT_W'(0))
                                 - (wb_valid_s ? CNT_W'(1) : CNT_W'(0));
    if (step_s && last_s) begin
      scan_next_s = ST_DRAIN;
    end else if (step_s && row_end_s) begin
      scan_next_s = ROW_GAP;
    end else begin
      scan_next_s = ST_SCAN;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = zero_s ? ST_DONE : scan_next_s;
        else          state_next_s = ST_IDLE;
      end
      ST_SCAN:  state_next_s = scan_next_s;
`ifdef FRAME_SEQ_HBLANK_EN
      ST_HBLANK: begin
        if (blank_cnt_r == BLK_W'(HBLANK - 1)) state_next_s = ST_SCAN;
        else                                   state_next_s = ST_HBLANK;
      end
`endif
      ST_DRAIN: begin
        if (inflight_next_s == '0) state_next_s = ST_DONE;
        else                       state_next_s = ST_DRAIN;
      end
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State, scan counters and registered pixel outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      w_r        <= '0;
      h_r        <= '0;
      pad_r      <= 2'd0;
      x_cnt_r    <= '0;
      y_cnt_r    <= '0;
      addr_cnt_r <= '0;
      inflight_r <= '0;
      en_r       <= 1'b0;
      hsync_r    <= 1'b0;
      vsync_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      x_r        <= '0;
      y_r        <= '0;
      rd_addr_r  <= '0;
    end else begin
      state_r    <= state_next_s;
      if (accept_s) begin
        w_r   <= bus.width;
        h_r   <= bus.height;
        pad_r <= bus.row_pad;
      end
      x_cnt_r    <= x_nxt_s;
      y_cnt_r    <= y_nxt_s;
      addr_cnt_r <= addr_nxt_s;
      inflight_r <= inflight_next_s;
      en_r       <= step_s;
      hsync_r    <= step_s && (cur_x_s == '0);
      vsync_r    <= step_s && (cur_x_s == '0) && (cur_y_s == '0);
      busy_r     <= (state_next_s != ST_IDLE);
      done_r     <= (state_next_s == ST_DONE);
      if (step_s) begin
        x_r       <= cur_x_s;
        y_r       <= cur_y_s;
        rd_addr_r <= cur_addr_s;
      end
    end
  end

`ifdef FRAME_SEQ_HBLANK_EN
  // Blank-cycle counter runs only inside ST_HBLANK and ignores stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   blank_cnt_r <= '0;
    else if (state_r == ST_HBLANK)  blank_cnt_r <= blank_cnt_r + BLK_W'(1);
    else                            blank_cnt_r <= '0;
  end
`endif

  seq_delay_line #(.ADDR_W(ADDR_W), .DEPTH(PIPE_LAT)) u_delay (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (en_r),
    .in_addr   (rd_addr_r),
    .out_valid (wb_valid_s),
    .out_addr  (wb_addr_s)
  );

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.en      = en_r;
  assign bus.hsync   = hsync_r;
  assign bus.vsync   = vsync_r;
  assign bus.x       = x_r;
  assign bus.y       = y_r;
  assign bus.rd_addr = rd_addr_r;
  assign bus.wr_en   = wb_valid_s;
  assign bus.wr_addr = wb_addr_s;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed self-checking bench for frame_sequencer (default PIPE_LAT=4, BPP=3).
module tb_frame_sequencer;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  frame_seq_if #(.ADDR_W(20), .DIM_W(11)) bus ();

  frame_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int w, input int h, input int pad);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.width   = 11'(w);
    bus.height  = 11'(h);
    bus.row_pad = 2'(pad);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},    32'(bus.en),      32'd0);
    chk({tag, "_busy"},  32'(bus.busy),    32'd0);
    chk({tag, "_done"},  32'(bus.done),    32'd0);
    chk({tag, "_wren"},  32'(bus.wr_en),   32'd0);
    chk({tag, "_hs"},    32'(bus.hsync),   32'd0);
    chk({tag, "_vs"},    32'(bus.vsync),   32'd0);
    chk({tag, "_x"},     32'(bus.x),       32'd0);
    chk({tag, "_y"},     32'(bus.y),       32'd0);
    chk({tag, "_rd"},    32'(bus.rd_addr), 32'd0);
    chk({tag, "_wa"},    32'(bus.wr_addr), 32'd0);
  endtask

  int t2_addr [6] = '{0, 3, 6, 12, 15, 18};
  int t3_en   [7] = '{0, 1, 1, 0, 0, 1, 1};
  int t3_x    [7] = '{0, 0, 1, 1, 1, 2, 3};
  int t3_rd   [7] = '{0, 0, 3, 3, 3, 6, 9};
  int t3_wa   [11] = '{0, 0, 0, 0, 0, 0, 3, 0, 0, 6, 9};
`ifdef FRAME_SEQ_HBLANK_EN
  int t6_en   [12] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
  int t6_done = 11;
`else
  int t6_en   [12] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
  int t6_done = 9;
`endif

  initial begin
    int wr_idx;
    n_chk       = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.width   = 11'd0;
    bus.height  = 11'd0;
    bus.row_pad = 2'd0;
    bus.stall   = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Test 1: W=4 H=2 pad=0, no stall
    pulse_start(4, 2, 0);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      chk("t1_en", 32'(bus.en), 32'(i <= 8));
      if (i <= 8) begin
        chk("t1_rd", 32'(bus.rd_addr), 32'(3 * (i - 1)));
        chk("t1_x",  32'(bus.x), 32'((i - 1) % 4));
        chk("t1_y",  32'(bus.y), 32'((i - 1) / 4));
        chk("t1_hs", 32'(bus.hsync), 32'((i == 1) || (i == 5)));
        chk("t1_vs", 32'(bus.vsync), 32'(i == 1));
      end
      chk("t1_wren", 32'(bus.wr_en), 32'((i >= 5) && (i <= 12)));
      if ((i >= 5) && (i <= 12)) chk("t1_wa", 32'(bus.wr_addr), 32'(3 * (i - 5)));
      chk("t1_done", 32'(bus.done), 32'(i == 13));
      chk("t1_busy", 32'(bus.busy), 32'(i <= 13));
    end

    // Test 2: W=3 H=2 pad=3
    pulse_start(3, 2, 3);
    wr_idx = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("t2_en", 32'(bus.en), 32'(i <= 6));
      if (i <= 6) chk("t2_rd", 32'(bus.rd_addr), 32'(t2_addr[i-1]));
      if (bus.wr_en === 1'b1 && wr_idx < 6) begin
        chk("t2_wa", 32'(bus.wr_addr), 32'(t2_addr[wr_idx]));
        wr_idx++;
      end
      chk("t2_done", 32'(bus.done), 32'(i == 11));
    end
    chk("t2_wrcnt", 32'(wr_idx), 32'd6);

    // Test 3: W=4 H=1, stall for two cycles before x=2
    pulse_start(4, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i <= 6) begin
        chk("t3_en", 32'(bus.en), 32'(t3_en[i]));
        chk("t3_x",  32'(bus.x),  32'(t3_x[i]));
        chk("t3_rd", 32'(bus.rd_addr), 32'(t3_rd[i]));
      end else begin
        chk("t3_en_idle", 32'(bus.en), 32'd0);
      end
      chk("t3_wren", 32'(bus.wr_en), 32'((i == 5) || (i == 6) || (i == 9) || (i == 10)));
      if (i <= 10 && bus.wr_en === 1'b1) chk("t3_wa", 32'(bus.wr_addr), 32'(t3_wa[i]));
      chk("t3_done", 32'(bus.done), 32'(i == 11));
      if (i == 2) bus.stall = 1'b1;
      if (i == 4) bus.stall = 1'b0;
    end

    // Test 4: W=0 H=5 goes straight to done; start during done is ignored
    pulse_start(0, 5, 0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("t4_done", 32'(bus.done), 32'(i == 1));
      chk("t4_busy", 32'(bus.busy), 32'(i == 1));
      chk("t4_en",   32'(bus.en),   32'd0);
      chk("t4_wren", 32'(bus.wr_en), 32'd0);
      if (i == 1) begin
        bus.start  = 1'b1;
        bus.width  = 11'd1;
        bus.height = 11'd1;
      end else begin
        bus.start  = 1'b0;
      end
    end

    // Test 5: start mid-frame ignored, then reset at y=1 aborts without done
    pulse_start(4, 2, 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("t5_en", 32'(bus.en), 32'd1);
      chk("t5_rd", 32'(bus.rd_addr), 32'(3 * (i - 1)));
      if (i == 2) begin
        bus.start = 1'b1;
        bus.width = 11'd2;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("t5_y1", 32'(bus.y), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_nodone", 32'(bus.done), 32'd0);
      chk("t5_nowr",   32'(bus.wr_en), 32'd0);
      chk("t5_noen",   32'(bus.en), 32'd0);
    end

    // Test 6: W=2 H=2, row blanking when enabled
    pulse_start(2, 2, 0);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      chk("t6_en",   32'(bus.en),   32'(t6_en[i]));
      chk("t6_done", 32'(bus.done), 32'(i == t6_done));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
